// File: rtl/riscv_core_idex_preg.sv
// riscv_core_idex_preg
//   ID/EX pipeline register bank. Captures the per-field writes from the ID
//   output stage and presents them registered to EX. It holds on stall. It
//   inserts a bubble on flush or on a load-use hazard, and it counts those
//   bubbles in a saturating counter. It also keeps the preserved ID
//   instruction and PC for replay.
//
// Ports
//   CLK, RST           clock (rising edge), asynchronous active-low reset
//   ACT, ID_VALID      ID stage active / holds a real instruction
//   STALL, FLUSH       hold everything / kill ID-EX contents
//   r_ex_<f>_D/_WE     per-field write data and enable
//   r_ex_<f>_Q         registered fields towards EX
//   r_ex_valid_Q       EX instruction valid
//   r_id_*_preserved_* preserved instruction / PC for replay
//   s_ld_use_hazard    combinational stall request to IF/ID
//   s_bubble_cnt       saturating count of inserted bubbles
module riscv_core_idex_preg #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ACT,
    input  logic             ID_VALID,
    input  logic             STALL,
    input  logic             FLUSH,
    input  logic [31:0]      r_ex_pc_D,
    input  logic             r_ex_pc_WE,
    input  logic [31:0]      r_ex_immed_D,
    input  logic             r_ex_immed_WE,
    input  logic [31:0]      r_ex_reg1_D,
    input  logic             r_ex_reg1_WE,
    input  logic [31:0]      r_ex_reg2_D,
    input  logic             r_ex_reg2_WE,
    input  logic [3:0]       r_ex_aluop_D,
    input  logic             r_ex_aluop_WE,
    input  logic [3:0]       r_ex_memop_D,
    input  logic             r_ex_memop_WE,
    input  logic [1:0]       r_ex_alusrc1_D,
    input  logic             r_ex_alusrc1_WE,
    input  logic [1:0]       r_ex_rfwt_sel_D,
    input  logic             r_ex_rfwt_sel_WE,
    input  logic [2:0]       r_ex_branchop_D,
    input  logic             r_ex_branchop_WE,
    input  logic             r_ex_alusrc2_D,
    input  logic             r_ex_alusrc2_WE,
    input  logic             r_ex_brnch_sel_D,
    input  logic             r_ex_brnch_sel_WE,
    input  logic             r_ex_regwrite_D,
    input  logic             r_ex_regwrite_WE,
    input  logic [4:0]       r_ex_rd_D,
    input  logic             r_ex_rd_WE,
    input  logic [4:0]       r_ex_rs1_D,
    input  logic             r_ex_rs1_WE,
    input  logic [4:0]       r_ex_rs2_D,
    input  logic             r_ex_rs2_WE,
    input  logic [31:0]      r_id_instr_preserved_D,
    input  logic             r_id_instr_preserved_WE,
    input  logic [31:0]      r_id_pc_preserved_D,
    input  logic             r_id_pc_preserved_WE,
    output logic [31:0]      r_ex_pc_Q,
    output logic [31:0]      r_ex_immed_Q,
    output logic [31:0]      r_ex_reg1_Q,
    output logic [31:0]      r_ex_reg2_Q,
    output logic [3:0]       r_ex_aluop_Q,
    output logic [3:0]       r_ex_memop_Q,
    output logic [1:0]       r_ex_alusrc1_Q,
    output logic [1:0]       r_ex_rfwt_sel_Q,
    output logic [2:0]       r_ex_branchop_Q,
    output logic             r_ex_alusrc2_Q,
    output logic             r_ex_brnch_sel_Q,
    output logic             r_ex_regwrite_Q,
    output logic [4:0]       r_ex_rd_Q,
    output logic [4:0]       r_ex_rs1_Q,
    output logic [4:0]       r_ex_rs2_Q,
    output logic             r_ex_valid_Q,
    output logic [31:0]      r_id_instr_preserved_Q,
    output logic [31:0]      r_id_pc_preserved_Q,
    output logic             s_ld_use_hazard,
    output logic [CNT_W-1:0] s_bubble_cnt
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] immed;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [3:0]  aluop;
        logic [3:0]  memop;
        logic [1:0]  alusrc1;
        logic [1:0]  rfwt_sel;
        logic [2:0]  branchop;
        logic        alusrc2;
        logic        brnch_sel;
        logic        regwrite;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ex_fields_t;

    ex_fields_t       ex_q, ex_d;
    logic             valid_q, valid_d;
    logic [31:0]      instr_pres_q, instr_pres_d;
    logic [31:0]      pc_pres_q, pc_pres_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;
    logic             bubble;

    // rs2 is compared even when the ID instruction does not read it; a rare
    // extra bubble is cheaper than decoding operand usage here.
    assign hazard = valid_q & ID_VALID & (ex_q.memop[3:2] == 2'b10) &
                    (ex_q.rd != 5'd0) &
                    ((ex_q.rd == r_ex_rs1_D) | (ex_q.rd == r_ex_rs2_D));

    // STALL masks the hazard bubble but never a flush.
    assign bubble = FLUSH | (~STALL & hazard);

    always_comb begin
        ex_d         = ex_q;
        valid_d      = valid_q;
        cnt_d        = cnt_q;
        instr_pres_d = instr_pres_q;
        pc_pres_d    = pc_pres_q;

        if (bubble) begin
            valid_d            = 1'b0;
            ex_d.regwrite      = 1'b0;
            ex_d.memop         = 4'b0000;
            ex_d.branchop      = 3'b000;
            ex_d.brnch_sel     = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!STALL) begin
            valid_d = ID_VALID & ACT;
            if (ACT) begin
                if (r_ex_pc_WE)        ex_d.pc        = r_ex_pc_D;
                if (r_ex_immed_WE)     ex_d.immed     = r_ex_immed_D;
                if (r_ex_reg1_WE)      ex_d.reg1      = r_ex_reg1_D;
                if (r_ex_reg2_WE)      ex_d.reg2      = r_ex_reg2_D;
                if (r_ex_aluop_WE)     ex_d.aluop     = r_ex_aluop_D;
                if (r_ex_memop_WE)     ex_d.memop     = r_ex_memop_D;
                if (r_ex_alusrc1_WE)   ex_d.alusrc1   = r_ex_alusrc1_D;
                if (r_ex_rfwt_sel_WE)  ex_d.rfwt_sel  = r_ex_rfwt_sel_D;
                if (r_ex_branchop_WE)  ex_d.branchop  = r_ex_branchop_D;
                if (r_ex_alusrc2_WE)   ex_d.alusrc2   = r_ex_alusrc2_D;
                if (r_ex_brnch_sel_WE) ex_d.brnch_sel = r_ex_brnch_sel_D;
                if (r_ex_regwrite_WE)  ex_d.regwrite  = r_ex_regwrite_D;
                if (r_ex_rd_WE)        ex_d.rd        = r_ex_rd_D;
                if (r_ex_rs1_WE)       ex_d.rs1       = r_ex_rs1_D;
                if (r_ex_rs2_WE)       ex_d.rs2       = r_ex_rs2_D;
            end
        end

        // Replay copies ignore flush/hazard; only a stall freezes them.
        if (!STALL) begin
            if (r_id_instr_preserved_WE) instr_pres_d = r_id_instr_preserved_D;
            if (r_id_pc_preserved_WE)    pc_pres_d    = r_id_pc_preserved_D;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ex_q         <= '0;
            valid_q      <= 1'b0;
            instr_pres_q <= '0;
            pc_pres_q    <= '0;
            cnt_q        <= '0;
        end else begin
            ex_q         <= ex_d;
            valid_q      <= valid_d;
            instr_pres_q <= instr_pres_d;
            pc_pres_q    <= pc_pres_d;
            cnt_q        <= cnt_d;
        end
    end

    assign r_ex_pc_Q              = ex_q.pc;
    assign r_ex_immed_Q           = ex_q.immed;
    assign r_ex_reg1_Q            = ex_q.reg1;
    assign r_ex_reg2_Q            = ex_q.reg2;
    assign r_ex_aluop_Q           = ex_q.aluop;
    assign r_ex_memop_Q           = ex_q.memop;
    assign r_ex_alusrc1_Q         = ex_q.alusrc1;
    assign r_ex_rfwt_sel_Q        = ex_q.rfwt_sel;
    assign r_ex_branchop_Q        = ex_q.branchop;
    assign r_ex_alusrc2_Q         = ex_q.alusrc2;
    assign r_ex_brnch_sel_Q       = ex_q.brnch_sel;
    assign r_ex_regwrite_Q        = ex_q.regwrite;
    assign r_ex_rd_Q              = ex_q.rd;
    assign r_ex_rs1_Q             = ex_q.rs1;
    assign r_ex_rs2_Q             = ex_q.rs2;
    assign r_ex_valid_Q           = valid_q;
    assign r_id_instr_preserved_Q = instr_pres_q;
    assign r_id_pc_preserved_Q    = pc_pres_q;
    assign s_ld_use_hazard        = hazard;
    assign s_bubble_cnt           = cnt_q;

endmodule

// File: tb/tb_riscv_core_idex_preg.sv
module tb_riscv_core_idex_preg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] immed;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [3:0]  aluop;
        logic [3:0]  memop;
        logic [1:0]  alusrc1;
        logic [1:0]  rfwt_sel;
        logic [2:0]  branchop;
        logic        alusrc2;
        logic        brnch_sel;
        logic        regwrite;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } fld_t;

    typedef struct packed {
        fld_t        f;
        logic        v;
        logic [31:0] ip;
        logic [31:0] pp;
        logic        hp;   // hazard just before the edge
        logic        haz;  // hazard just after the edge
        logic [3:0]  cnt;
    } exp_t;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic        rst_n, act, id_valid, stall, flush;
    fld_t        din;
    logic [14:0] we;
    logic [31:0] ip_d, pp_d;
    logic        ip_we, pp_we;

    fld_t        q;
    logic        valid_q, haz;
    logic [31:0] ip_q, pp_q;
    logic [3:0]  cnt;

    riscv_core_idex_preg #(.CNT_W(4)) dut (
        .CLK(clk), .RST(rst_n), .ACT(act), .ID_VALID(id_valid),
        .STALL(stall), .FLUSH(flush),
        .r_ex_pc_D(din.pc),               .r_ex_pc_WE(we[0]),
        .r_ex_immed_D(din.immed),         .r_ex_immed_WE(we[1]),
        .r_ex_reg1_D(din.reg1),           .r_ex_reg1_WE(we[2]),
        .r_ex_reg2_D(din.reg2),           .r_ex_reg2_WE(we[3]),
        .r_ex_aluop_D(din.aluop),         .r_ex_aluop_WE(we[4]),
        .r_ex_memop_D(din.memop),         .r_ex_memop_WE(we[5]),
        .r_ex_alusrc1_D(din.alusrc1),     .r_ex_alusrc1_WE(we[6]),
        .r_ex_rfwt_sel_D(din.rfwt_sel),   .r_ex_rfwt_sel_WE(we[7]),
        .r_ex_branchop_D(din.branchop),   .r_ex_branchop_WE(we[8]),
        .r_ex_alusrc2_D(din.alusrc2),     .r_ex_alusrc2_WE(we[9]),
        .r_ex_brnch_sel_D(din.brnch_sel), .r_ex_brnch_sel_WE(we[10]),
        .r_ex_regwrite_D(din.regwrite),   .r_ex_regwrite_WE(we[11]),
        .r_ex_rd_D(din.rd),               .r_ex_rd_WE(we[12]),
        .r_ex_rs1_D(din.rs1),             .r_ex_rs1_WE(we[13]),
        .r_ex_rs2_D(din.rs2),             .r_ex_rs2_WE(we[14]),
        .r_id_instr_preserved_D(ip_d),    .r_id_instr_preserved_WE(ip_we),
        .r_id_pc_preserved_D(pp_d),       .r_id_pc_preserved_WE(pp_we),
        .r_ex_pc_Q(q.pc),                 .r_ex_immed_Q(q.immed),
        .r_ex_reg1_Q(q.reg1),             .r_ex_reg2_Q(q.reg2),
        .r_ex_aluop_Q(q.aluop),           .r_ex_memop_Q(q.memop),
        .r_ex_alusrc1_Q(q.alusrc1),       .r_ex_rfwt_sel_Q(q.rfwt_sel),
        .r_ex_branchop_Q(q.branchop),     .r_ex_alusrc2_Q(q.alusrc2),
        .r_ex_brnch_sel_Q(q.brnch_sel),   .r_ex_regwrite_Q(q.regwrite),
        .r_ex_rd_Q(q.rd),                 .r_ex_rs1_Q(q.rs1),
        .r_ex_rs2_Q(q.rs2),               .r_ex_valid_Q(valid_q),
        .r_id_instr_preserved_Q(ip_q),    .r_id_pc_preserved_Q(pp_q),
        .s_ld_use_hazard(haz),            .s_bubble_cnt(cnt)
    );

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Stimulus record: distinct, mostly non-zero values derived from pc.
    function automatic fld_t mk(input logic [31:0] p, input logic [3:0] m,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2);
        fld_t r;
        r.pc = p;            r.immed = p ^ 32'h5A5A_0000;
        r.reg1 = p | 32'hA000_0000;  r.reg2 = ~p;
        r.aluop = p[5:2] ^ 4'h9;     r.memop = m;
        r.alusrc1 = 2'b10;   r.rfwt_sel = 2'b01;  r.branchop = 3'b101;
        r.alusrc2 = 1'b1;    r.brnch_sel = 1'b1;  r.regwrite = 1'b1;
        r.rd = rd;           r.rs1 = rs1;         r.rs2 = rs2;
        return r;
    endfunction

    function automatic fld_t bub(input fld_t x);
        fld_t r = x;
        r.memop = 4'b0000; r.regwrite = 1'b0;
        r.branchop = 3'b000; r.brnch_sel = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] ipv(input logic [31:0] p);
        return {16'hC0DE, p[15:0]};
    endfunction

    function automatic exp_t mke(input fld_t f, input logic v,
                                 input logic [31:0] ip, input logic [31:0] pp,
                                 input logic hp, input logic hz,
                                 input logic [3:0] c);
        exp_t e;
        e.f = f; e.v = v; e.ip = ip; e.pp = pp; e.hp = hp; e.haz = hz; e.cnt = c;
        return e;
    endfunction

    task automatic drive(input fld_t d);
        din  = d;
        ip_d = ipv(d.pc);
        pp_d = d.pc;
    endtask

    // Inputs for the coming edge are already applied; queue the expected
    // post-edge state and move on to the next falling edge.
    task automatic vec(input exp_t e);
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: hazard sampled 1 time unit before each rising edge, state 1
    // time unit after it.
    logic hp_s;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4 hp_s = haz;
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if (q !== e.f) begin
                    n_err++;
                    $display("FAIL vec%0d fields: got %h want %h", n_vec, q, e.f);
                end
                if (valid_q !== e.v) begin
                    n_err++;
                    $display("FAIL vec%0d valid: got %b want %b", n_vec, valid_q, e.v);
                end
                if (ip_q !== e.ip || pp_q !== e.pp) begin
                    n_err++;
                    $display("FAIL vec%0d preserved: got %h/%h want %h/%h",
                             n_vec, ip_q, pp_q, e.ip, e.pp);
                end
                if (hp_s !== e.hp) begin
                    n_err++;
                    $display("FAIL vec%0d hazard_pre: got %b want %b", n_vec, hp_s, e.hp);
                end
                if (haz !== e.haz) begin
                    n_err++;
                    $display("FAIL vec%0d hazard_post: got %b want %b", n_vec, haz, e.haz);
                end
                if (cnt !== e.cnt) begin
                    n_err++;
                    $display("FAIL vec%0d bubble_cnt: got %0d want %0d", n_vec, cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        fld_t d1, d2, d3, d4, d5, d6, d7, d8, d9, d10, d11, d12, cur;
        logic [3:0] c;

        rst_n = 1'b0; act = 1'b1; id_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        we = '1; ip_we = 1'b1; pp_we = 1'b1;
        drive(mk(32'h1111_1111, 4'b1000, 5'd3, 5'd3, 5'd3));
        @(negedge clk);

        // reset with busy inputs
        vec(mke('0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0));
        vec(mke('0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0));

        // first load after reset
        rst_n = 1'b1;
        d1 = mk(32'h0000_0100, 4'b0000, 5'd1, 5'd2, 5'd3);
        drive(d1);
        vec(mke(d1, 1'b1, ipv(d1.pc), d1.pc, 1'b0, 1'b0, 4'd0));

        // load into EX, rd=5, no dependency
        d2 = mk(32'h0000_0104, 4'b1000, 5'd5, 5'd6, 5'd7);
        drive(d2);
        vec(mke(d2, 1'b1, ipv(d2.pc), d2.pc, 1'b0, 1'b0, 4'd0));

        // dependent rs1=5: bubble, then the held instruction loads
        d3 = mk(32'h0000_0108, 4'b0000, 5'd8, 5'd5, 5'd9);
        drive(d3);
        vec(mke(bub(d2), 1'b0, ipv(d3.pc), d3.pc, 1'b1, 1'b0, 4'd1));
        vec(mke(d3, 1'b1, ipv(d3.pc), d3.pc, 1'b0, 1'b0, 4'd1));

        // load rd=10, then stall 3 cycles with a dependent (rs1=10) in ID
        d4 = mk(32'h0000_010C, 4'b1000, 5'd10, 5'd1, 5'd2);
        drive(d4);
        vec(mke(d4, 1'b1, ipv(d4.pc), d4.pc, 1'b0, 1'b0, 4'd1));
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d5 = mk(32'h0000_0110 + 32'(k * 4), 4'b0000, 5'd3, 5'd10, 5'd4);
            drive(d5);
            vec(mke(d4, 1'b1, ipv(d4.pc), d4.pc, 1'b1, 1'b1, 4'd1));
        end
        stall = 1'b0;
        vec(mke(bub(d4), 1'b0, ipv(d5.pc), d5.pc, 1'b1, 1'b0, 4'd2));
        vec(mke(d5, 1'b1, ipv(d5.pc), d5.pc, 1'b0, 1'b0, 4'd2));

        // store with rd==rs1: no hazard
        d6 = mk(32'h0000_0200, 4'b1100, 5'd7, 5'd7, 5'd1);
        drive(d6);
        vec(mke(d6, 1'b1, ipv(d6.pc), d6.pc, 1'b0, 1'b0, 4'd2));

        // FLUSH and STALL together: flush wins, preserved held by stall
        flush = 1'b1; stall = 1'b1;
        d7 = mk(32'h0000_0300, 4'b1000, 5'd2, 5'd2, 5'd2);
        drive(d7);
        vec(mke(bub(d6), 1'b0, ipv(d6.pc), d6.pc, 1'b0, 1'b0, 4'd3));
        flush = 1'b0; stall = 1'b0;

        // rd=0 load with rs1=0: no hazard
        d8 = mk(32'h0000_0400, 4'b1000, 5'd0, 5'd0, 5'd0);
        drive(d8);
        vec(mke(d8, 1'b1, ipv(d8.pc), d8.pc, 1'b0, 1'b0, 4'd3));

        // ACT=0: data holds, valid drops, preserved still loads
        act = 1'b0;
        d9 = mk(32'h0000_0500, 4'b0000, 5'd4, 5'd4, 5'd4);
        drive(d9);
        vec(mke(d8, 1'b0, ipv(d9.pc), d9.pc, 1'b0, 1'b0, 4'd3));
        act = 1'b1;

        // partial write enables: only pc and rd update; rs1_D=9 then hits
        we = 15'b001_0000_0000_0001;
        ip_we = 1'b0; pp_we = 1'b0;
        d10 = mk(32'h0000_0600, 4'b0000, 5'd9, 5'd9, 5'd1);
        drive(d10);
        cur = d8; cur.pc = 32'h0000_0600; cur.rd = 5'd9;
        vec(mke(cur, 1'b1, ipv(d9.pc), d9.pc, 1'b0, 1'b1, 4'd3));

        // ID_VALID=0 masks the hazard; fields load, valid goes low
        we = '1; ip_we = 1'b1; pp_we = 1'b1; id_valid = 1'b0;
        d11 = mk(32'h0000_0640, 4'b0000, 5'd6, 5'd9, 5'd9);
        drive(d11);
        vec(mke(d11, 1'b0, ipv(d11.pc), d11.pc, 1'b0, 1'b0, 4'd3));
        id_valid = 1'b1;

        // 20 flushes: counter climbs from 3 and saturates at 15
        flush = 1'b1; ip_we = 1'b0; pp_we = 1'b0;
        c = 4'd3;
        for (int k = 0; k < 20; k++) begin
            if (c != 4'hF) c = c + 4'd1;
            vec(mke(bub(d11), 1'b0, ipv(d11.pc), d11.pc, 1'b0, 1'b0, c));
        end
        flush = 1'b0; ip_we = 1'b1; pp_we = 1'b1;

        // valid load, then reset mid-operation drops it
        d12 = mk(32'h0000_0700, 4'b0000, 5'd1, 5'd2, 5'd3);
        drive(d12);
        vec(mke(d12, 1'b1, ipv(d12.pc), d12.pc, 1'b0, 1'b0, 4'hF));
        rst_n = 1'b0;
        vec(mke('0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0));
        vec(mke('0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0));

        // counter restarts from zero
        rst_n = 1'b1; flush = 1'b1; ip_we = 1'b0; pp_we = 1'b0;
        vec(mke('0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd1));
        flush = 1'b0;

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
